// File: rtl/div_wb_if.sv
// Issue/writeback bundle between decode/execute, the divide unit and the register file.
// The master issues operations; the slave (divide unit) reports status and drives the write port.
interface div_wb_if #(
    parameter int DATA_WIDTH    = 32,
    parameter int ADDRESS_WIDTH = 5
);
    logic                     start;
    logic [1:0]               op;
    logic [DATA_WIDTH-1:0]    op_a;
    logic [DATA_WIDTH-1:0]    op_b;
    logic [ADDRESS_WIDTH-1:0] rd;
    logic                     busy;
    logic                     done;
    logic                     wb_en;
    logic [ADDRESS_WIDTH-1:0] wb_addr;
    logic [DATA_WIDTH-1:0]    wb_data;

    modport master (
        output start, op, op_a, op_b, rd,
        input  busy, done, wb_en, wb_addr, wb_data
    );

    modport slave (
        input  start, op, op_a, op_b, rd,
        output busy, done, wb_en, wb_addr, wb_data
    );
endinterface

// File: rtl/div_wb_unit.sv
// Iterative RV32M DIV/DIVU/REM/REMU unit (restoring, one quotient bit per cycle)
// that writes its result straight into the register file for a single cycle.
module div_wb_unit #(
    parameter int DATA_WIDTH    = 32,
    parameter int ADDRESS_WIDTH = 5
) (
    input  logic    clk,
    input  logic    rst,
    div_wb_if.slave bus
);
    localparam int CNT_W = $clog2(DATA_WIDTH + 1);
    localparam logic [DATA_WIDTH-1:0] ONE      = {{(DATA_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [DATA_WIDTH-1:0] MIN_NEG  = {1'b1, {(DATA_WIDTH-1){1'b0}}};
    localparam logic [DATA_WIDTH-1:0] ALL_ONES = {DATA_WIDTH{1'b1}};
    localparam logic [CNT_W-1:0]      CNT_LOAD = CNT_W'(DATA_WIDTH);
    localparam logic [CNT_W-1:0]      CNT_LAST = {{(CNT_W-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        WB   = 2'd2
    } state_t;

    state_t state, state_nxt;

    // dvd_q starts as the dividend magnitude; quotient bits shift in from the bottom.
    logic [DATA_WIDTH-1:0]    dvd_q;
    logic [DATA_WIDTH-1:0]    dvs_q;
    logic [DATA_WIDTH-1:0]    rem_q;
    logic [CNT_W-1:0]         cnt_q;
    logic                     sel_rem_q;
    logic                     neg_quo_q;
    logic                     neg_rem_q;
    logic [ADDRESS_WIDTH-1:0] rd_q;
    logic [ADDRESS_WIDTH-1:0] wb_addr_q;
    logic [DATA_WIDTH-1:0]    wb_data_q;

    function automatic logic [DATA_WIDTH-1:0] negate_if(
        input logic [DATA_WIDTH-1:0] v,
        input logic                  flag
    );
        return flag ? (~v + ONE) : v;
    endfunction

    logic signed [DATA_WIDTH-1:0] a_s;
    logic signed [DATA_WIDTH-1:0] b_s;
    logic                         is_signed;
    logic                         a_neg;
    logic                         b_neg;
    logic                         div_zero;
    logic                         overflow;
    logic                         special;
    logic                         accept;
    logic [DATA_WIDTH-1:0]        special_res;

    // op[0]=1 selects unsigned, op[1]=1 selects remainder.
    always_comb begin
        a_s         = $signed(bus.op_a);
        b_s         = $signed(bus.op_b);
        is_signed   = ~bus.op[0];
        a_neg       = is_signed && (a_s < 0);
        b_neg       = is_signed && (b_s < 0);
        div_zero    = (bus.op_b == '0);
        overflow    = is_signed && (bus.op_a == MIN_NEG) && (bus.op_b == ALL_ONES);
        special     = div_zero || overflow;
        accept      = (state == IDLE) && bus.start;
        special_res = '0;
        if (div_zero) begin
            special_res = bus.op[1] ? bus.op_a : ALL_ONES;
        end else begin
            special_res = bus.op[1] ? '0 : MIN_NEG;
        end
    end

    logic [DATA_WIDTH:0]   p_shift;
    logic                  p_ge;
    logic [DATA_WIDTH-1:0] rem_step;
    logic [DATA_WIDTH-1:0] quo_step;
    logic [DATA_WIDTH-1:0] calc_res;

    // One restoring step; the remainder after a successful subtract always fits DATA_WIDTH bits.
    always_comb begin
        p_shift  = {rem_q, dvd_q[DATA_WIDTH-1]};
        p_ge     = (p_shift >= {1'b0, dvs_q});
        rem_step = DATA_WIDTH'(p_ge ? (p_shift - {1'b0, dvs_q}) : p_shift);
        quo_step = {dvd_q[DATA_WIDTH-2:0], p_ge};
        calc_res = sel_rem_q ? negate_if(rem_step, neg_rem_q)
                             : negate_if(quo_step, neg_quo_q);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        bus.busy    = 1'b0;
        bus.done    = 1'b0;
        bus.wb_en   = 1'b0;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    state_nxt = special ? WB : CALC;
                end
            end
            CALC: begin
                bus.busy = 1'b1;
                if (cnt_q == CNT_LAST) begin
                    state_nxt = WB;
                end
            end
            WB: begin
                bus.busy  = 1'b1;
                bus.done  = 1'b1;
                // x0 is not write-protected in the register file.
                bus.wb_en = (wb_addr_q != '0);
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign bus.wb_addr = wb_addr_q;
    assign bus.wb_data = wb_data_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            dvd_q     <= '0;
            dvs_q     <= '0;
            rem_q     <= '0;
            cnt_q     <= '0;
            sel_rem_q <= 1'b0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
            rd_q      <= '0;
            wb_addr_q <= '0;
            wb_data_q <= '0;
        end else if (accept) begin
            dvd_q     <= negate_if(bus.op_a, a_neg);
            dvs_q     <= negate_if(bus.op_b, b_neg);
            rem_q     <= '0;
            cnt_q     <= CNT_LOAD;
            sel_rem_q <= bus.op[1];
            neg_quo_q <= a_neg ^ b_neg;
            neg_rem_q <= a_neg;
            rd_q      <= bus.rd;
            // Divide-by-zero and overflow skip the iteration and write next cycle.
            if (special) begin
                wb_addr_q <= bus.rd;
                wb_data_q <= special_res;
            end
        end else if (state == CALC) begin
            dvd_q <= quo_step;
            rem_q <= rem_step;
            cnt_q <= cnt_q - CNT_LAST;
            if (cnt_q == CNT_LAST) begin
                wb_addr_q <= rd_q;
                wb_data_q <= calc_res;
            end
        end
    end
endmodule

// File: tb/tb_div_wb_unit.sv
// Bench for div_wb_unit: directed vector table, hand-written reset/busy sequences,
// and random operations checked against a plain-arithmetic RV32M model.
module tb_div_wb_unit;
    localparam int DW = 32;
    localparam int AW = 5;
    localparam logic [1:0] OP_DIV  = 2'b00;
    localparam logic [1:0] OP_DIVU = 2'b01;
    localparam logic [1:0] OP_REM  = 2'b10;
    localparam logic [1:0] OP_REMU = 2'b11;

    logic clk = 1'b0;
    logic rst;

    div_wb_if #(.DATA_WIDTH(DW), .ADDRESS_WIDTH(AW)) bus ();

    div_wb_unit #(.DATA_WIDTH(DW), .ADDRESS_WIDTH(AW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  rd;
        logic [31:0] exp;
        int          lat;
    } vec_t;

    vec_t vecs [15];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] ref_result(input logic [1:0] op, input logic [31:0] a,
                                               input logic [31:0] b);
        logic signed [31:0] sa;
        logic signed [31:0] sb;
        logic               ovf;
        sa  = a;
        sb  = b;
        ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        if (b == 32'd0) return op[1] ? a : 32'hFFFF_FFFF;
        case (op)
            OP_DIVU: return a / b;
            OP_REMU: return a % b;
            OP_DIV:  return ovf ? 32'h8000_0000 : 32'(sa / sb);
            default: return ovf ? 32'd0 : 32'(sa % sb);
        endcase
    endfunction

    function automatic int ref_latency(input logic [1:0] op, input logic [31:0] a,
                                       input logic [31:0] b);
        if (b == 32'd0) return 1;
        if (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
        return DW + 1;
    endfunction

    task automatic run_op(input string name, input logic [1:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [4:0] rd,
                          input logic [31:0] exp_data, input int exp_lat, input bit noise);
        int          lat;
        logic        busy_bad;
        logic        early_en;
        logic        held;
        logic [31:0] d0;
        logic [4:0]  ad0;
        @(negedge clk);
        bus.start = 1'b1;
        bus.op    = op;
        bus.op_a  = a;
        bus.op_b  = b;
        bus.rd    = rd;
        d0        = bus.wb_data;
        ad0       = bus.wb_addr;
        @(negedge clk);
        bus.start = 1'b0;
        lat       = 1;
        busy_bad  = 1'b0;
        early_en  = 1'b0;
        held      = 1'b1;
        while (bus.done !== 1'b1 && lat < 100) begin
            if (bus.busy !== 1'b1) busy_bad = 1'b1;
            if (bus.wb_en !== 1'b0) early_en = 1'b1;
            if (bus.wb_data !== d0 || bus.wb_addr !== ad0) held = 1'b0;
            if (noise) begin
                bus.start = 1'($urandom_range(0, 1));
                bus.op    = 2'($urandom);
                bus.op_a  = $urandom;
                bus.op_b  = $urandom_range(0, 3);
                bus.rd    = 5'($urandom);
            end
            @(negedge clk);
            lat++;
        end
        bus.start = 1'b0;
        check({name, " latency"}, 32'(lat), 32'(exp_lat));
        check({name, " busy_at_done"}, 32'(bus.busy), 32'd1);
        check({name, " wb_data"}, bus.wb_data, exp_data);
        check({name, " wb_addr"}, 32'(bus.wb_addr), 32'(rd));
        check({name, " wb_en"}, 32'(bus.wb_en), 32'(rd != 5'd0));
        check({name, " busy_through"}, 32'(busy_bad), 32'd0);
        check({name, " no_early_wb"}, 32'(early_en), 32'd0);
        check({name, " out_hold"}, 32'(held), 32'd1);
        @(negedge clk);
        check({name, " idle_after"}, {29'd0, bus.busy, bus.done, bus.wb_en}, 32'd0);
        check({name, " data_hold"}, bus.wb_data, exp_data);
    endtask

    initial begin
        logic        en_seen;
        logic [1:0]  rop;
        logic [31:0] ra;
        logic [31:0] rb;
        logic [4:0]  rrd;

        vecs[0]  = '{OP_DIVU, 32'd100,        32'd7,          5'd5,  32'd14,         33};
        vecs[1]  = '{OP_REMU, 32'd100,        32'd7,          5'd5,  32'd2,          33};
        vecs[2]  = '{OP_DIV,  32'hFFFF_FFF9,  32'd2,          5'd3,  32'hFFFF_FFFD,  33};
        vecs[3]  = '{OP_REM,  32'hFFFF_FFF9,  32'd2,          5'd3,  32'hFFFF_FFFF,  33};
        vecs[4]  = '{OP_DIV,  32'hFFFF_FFF9,  32'hFFFF_FFFE,  5'd3,  32'd3,          33};
        vecs[5]  = '{OP_DIVU, 32'h0000_1234,  32'd0,          5'd8,  32'hFFFF_FFFF,  1};
        vecs[6]  = '{OP_REMU, 32'h0000_1234,  32'd0,          5'd8,  32'h0000_1234,  1};
        vecs[7]  = '{OP_DIV,  32'h8000_0000,  32'hFFFF_FFFF,  5'd9,  32'h8000_0000,  1};
        vecs[8]  = '{OP_REM,  32'h8000_0000,  32'hFFFF_FFFF,  5'd9,  32'd0,          1};
        vecs[9]  = '{OP_DIVU, 32'd10,         32'd3,          5'd0,  32'd3,          33};
        vecs[10] = '{OP_DIV,  32'd5,          32'd0,          5'd4,  32'hFFFF_FFFF,  1};
        vecs[11] = '{OP_REM,  32'hFFFF_FFF9,  32'd0,          5'd6,  32'hFFFF_FFF9,  1};
        vecs[12] = '{OP_DIVU, 32'hFFFF_FFFF,  32'd1,          5'd31, 32'hFFFF_FFFF,  33};
        vecs[13] = '{OP_REM,  32'd7,          32'hFFFF_FFFE,  5'd1,  32'd1,          33};
        vecs[14] = '{OP_DIV,  32'h8000_0000,  32'd1,          5'd2,  32'h8000_0000,  33};

        rst       = 1'b1;
        bus.start = 1'b0;
        bus.op    = 2'b00;
        bus.op_a  = '0;
        bus.op_b  = '0;
        bus.rd    = '0;
        repeat (3) @(negedge clk);
        check("reset busy/done/wb_en", {29'd0, bus.busy, bus.done, bus.wb_en}, 32'd0);
        check("reset wb_addr", 32'(bus.wb_addr), 32'd0);
        check("reset wb_data", bus.wb_data, 32'd0);
        rst = 1'b0;

        for (int i = 0; i < 15; i++) begin
            run_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].rd,
                   vecs[i].exp, vecs[i].lat, 1'b0);
        end

        // Start pulses while busy must not disturb the operation in flight.
        run_op("busy_ignore", OP_DIVU, 32'd100, 32'd7, 5'd5, 32'd14, 33, 1'b1);

        // Reset in the middle of CALC aborts without any write.
        @(negedge clk);
        bus.start = 1'b1;
        bus.op    = OP_DIVU;
        bus.op_a  = 32'd100;
        bus.op_b  = 32'd7;
        bus.rd    = 5'd5;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (9) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("midreset busy/done/wb_en", {29'd0, bus.busy, bus.done, bus.wb_en}, 32'd0);
        check("midreset wb_addr", 32'(bus.wb_addr), 32'd0);
        check("midreset wb_data", bus.wb_data, 32'd0);
        en_seen = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (bus.wb_en !== 1'b0 || bus.done !== 1'b0 || bus.busy !== 1'b0) en_seen = 1'b1;
        end
        check("midreset no_activity", 32'(en_seen), 32'd0);

        // Reset wins over a simultaneous start.
        bus.start = 1'b1;
        bus.op    = OP_DIVU;
        bus.op_a  = 32'd10;
        bus.op_b  = 32'd0;
        bus.rd    = 5'd2;
        rst       = 1'b1;
        @(negedge clk);
        rst       = 1'b0;
        bus.start = 1'b0;
        check("rst_vs_start busy", 32'(bus.busy), 32'd0);
        @(negedge clk);
        check("rst_vs_start no_wb", {30'd0, bus.done, bus.wb_en}, 32'd0);

        for (int n = 0; n < 150; n++) begin
            rop = 2'($urandom);
            case ($urandom_range(0, 9))
                0:       rb = 32'd0;
                1:       rb = 32'hFFFF_FFFF;
                2, 3:    rb = $urandom_range(1, 15);
                default: rb = $urandom;
            endcase
            case ($urandom_range(0, 7))
                0:       ra = 32'h8000_0000;
                1:       ra = $urandom_range(0, 20);
                default: ra = $urandom;
            endcase
            rrd = 5'($urandom);
            run_op($sformatf("rnd%0d", n), rop, ra, rb, rrd, ref_result(rop, ra, rb),
                   ref_latency(rop, ra, rb), 1'($urandom_range(0, 1)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
